jpc_regfile_mp: RTL and testbench
=================================

Name: jpc_regfile_mp

Overview:
Parametrised multi-port successor to the single-port jpc_regfile.
- Configurable register count, data width, read-port count and write-port count.
- Each read port has a valid/ready index handshake and a registered, stall-holding data output.
- Sits between decode (operand fetch) and writeback in the jpc core.

Parameters:
NUM_REGS, 32, number of architectural registers (power of two, 2..256)
DATA_W, 32, register data width in bits
NUM_RD, 2, number of independent read ports
NUM_WR, 1, number of independent write ports
IDX_W, $clog2(NUM_REGS), index width (derived, do not override)
ZERO_REG, 1, 1 = register 0 hardwired to zero; 0 = register 0 is writable

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
rd_idx_I  input  NUM_RD*IDX_W  read index per port; port p occupies bits [p*IDX_W +: IDX_W]
rd_idx_valid_I  input  NUM_RD  read request valid per port
rd_idx_ready_O  output  NUM_RD  read request accepted per port
rd_data_O  output  NUM_RD*DATA_W  read data per port; port p occupies bits [p*DATA_W +: DATA_W]
rd_data_valid_O  output  NUM_RD  read data valid per port
rd_data_ready_I  input  NUM_RD  consumer ready for read data per port
wr_idx_I  input  NUM_WR*IDX_W  write index per port
wr_data_I  input  NUM_WR*DATA_W  write data per port
wr_valid_I  input  NUM_WR  write request per port
wr_ready_O  output  NUM_WR  write accepted per port

Behaviour:
- Reset (rst=1 at a rising edge):
  - all registers cleared to 0
  - rd_data_valid_O=0, rd_data_O=0
  - rd_idx_ready_O=0 and wr_ready_O=0 while rst is high
- Write ports:
  - wr_ready_O=1 whenever rst=0.
  - A write commits at the edge where wr_valid_I=1.
  - Same index written by several ports in one cycle: the highest-numbered port wins.
  - Write to index 0 is dropped when ZERO_REG=1.
  - Write to an index >= NUM_REGS is dropped.
- Read ports: each port is independent, with one output register and a two-state machine, EMPTY/FULL (rd_data_valid_O=0/1).
  - rd_idx_ready_O[p] = !rst && (!rd_data_valid_O[p] || rd_data_ready_I[p]).
  - Accept = rd_idx_valid_I && rd_idx_ready_O.
  - EMPTY, accept: next cycle FULL, with rd_data_O = register value sampled at the accept edge. This is the pre-write value unless bypass is enabled. Latency is 1 cycle.
  - FULL, data_ready=1 and a new accept: stay FULL and load the new data (back-to-back, 1 read/cycle).
  - FULL, data_ready=1 and no accept: go to EMPTY. rd_data_O holds its last value (don't-care).
  - FULL, data_ready=0: hold. rd_data_O stays stable even if the source register is written meanwhile (snapshot semantics).
- Reads:
  - Index 0 with ZERO_REG=1 returns 0.
  - Index >= NUM_REGS returns 0.
  - Ports reading the same index in the same cycle all get the same value.
- Reset mid-operation: pending read data is discarded, valid drops the cycle after rst is sampled, and register contents are cleared.

Optional Feature:
JPC_REGFILE_BYPASS_EN
- Defined: a read accepted in the same cycle as a committed write to the same (writable) index returns the new write data. With multiple writers to that index, the highest-numbered write port's data is returned.
- Undefined: the read returns the old value. The new value is visible to reads accepted from the next cycle on.
- Write/drop rules are identical in both builds.

Test Plan:
- Reset with rst=1 for 1 cycle, then read every index on port 0 -> rd_data_valid_O=0 during and right after reset, and all reads return 0x00000000.
- Write 0xDEADBEEF to r5 on wr port 0, then read r5 on rd ports 0 and 1 in the same cycle -> both rd_data_O=0xDEADBEEF, with valid 1 cycle after accept.
- Write 0x12345678 to r0 (ZERO_REG=1), then read r0 -> 0x00000000. Repeat with ZERO_REG=0 -> 0x12345678.
- Read r7 (=0x11), hold rd_data_ready_I=0 for 3 cycles while writing 0x22 to r7:
  - rd_data_O stays 0x11 with valid=1 and rd_idx_ready_O=0.
  - After ready=1, the next read returns 0x22.
- NUM_WR=2: both ports write r3 in the same cycle (port0 0xAAAA, port1 0xBBBB) -> a later read returns 0xBBBB. Same-cycle read of r3 returns 0xBBBB with JPC_REGFILE_BYPASS_EN, and the old value without it.
- Back-to-back reads of r1,r2,r3 on port 0 with data_ready=1 -> one result per cycle in order, no bubble. Asserting rst mid-stream -> valid=0 the next cycle and a later read of r1 returns 0.

Source files
------------

// File: rtl/jpc_regfile_mp.sv
// Multi-port register file: NUM_WR write ports, NUM_RD read ports with registered, stall-holding outputs.
// Optional same-cycle write-to-read bypass is enabled by defining JPC_REGFILE_BYPASS_EN.
module jpc_regfile_mp #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int IDX_W    = $clog2(NUM_REGS),
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*IDX_W-1:0]  rd_idx_I,
  input  logic [NUM_RD-1:0]        rd_idx_valid_I,
  output logic [NUM_RD-1:0]        rd_idx_ready_O,
  output logic [NUM_RD*DATA_W-1:0] rd_data_O,
  output logic [NUM_RD-1:0]        rd_data_valid_O,
  input  logic [NUM_RD-1:0]        rd_data_ready_I,
  input  logic [NUM_WR*IDX_W-1:0]  wr_idx_I,
  input  logic [NUM_WR*DATA_W-1:0] wr_data_I,
  input  logic [NUM_WR-1:0]        wr_valid_I,
  output logic [NUM_WR-1:0]        wr_ready_O
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} rd_state_t;

  logic [DATA_W-1:0] regs      [NUM_REGS];
  logic [DATA_W-1:0] rd_val    [NUM_RD];
  logic [DATA_W-1:0] rd_data_q [NUM_RD];
  rd_state_t         state_q   [NUM_RD];
  rd_state_t         state_d   [NUM_RD];
  logic [NUM_RD-1:0] accept;

  // An index is live storage if it is in range and not the hardwired zero register.
  function automatic logic reg_ok(input logic [IDX_W-1:0] idx);
    return (int'(idx) < NUM_REGS) && !((ZERO_REG != 0) && (idx == '0));
  endfunction

  assign wr_ready_O = {NUM_WR{!rst}};

  // Ports are scanned in ascending order so the highest-numbered writer wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_valid_I[w] && reg_ok(wr_idx_I[w*IDX_W +: IDX_W]))
          regs[wr_idx_I[w*IDX_W +: IDX_W]] <= wr_data_I[w*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_val[p] = '0;
      if (reg_ok(rd_idx_I[p*IDX_W +: IDX_W]))
        rd_val[p] = regs[rd_idx_I[p*IDX_W +: IDX_W]];
`ifdef JPC_REGFILE_BYPASS_EN
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_valid_I[w] && reg_ok(wr_idx_I[w*IDX_W +: IDX_W]) &&
            (wr_idx_I[w*IDX_W +: IDX_W] == rd_idx_I[p*IDX_W +: IDX_W]))
          rd_val[p] = wr_data_I[w*DATA_W +: DATA_W];
      end
`endif
    end
  end

  // Read-port state register and snapshot data register.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_RD; p++) begin
      if (rst) begin
        state_q[p]   <= EMPTY;
        rd_data_q[p] <= '0;
      end else begin
        state_q[p] <= state_d[p];
        if (accept[p]) rd_data_q[p] <= rd_val[p];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      state_d[p] = state_q[p];
      case (state_q[p])
        EMPTY:   if (accept[p]) state_d[p] = FULL;
        FULL:    if (rd_data_ready_I[p] && !accept[p]) state_d[p] = EMPTY;
        default: state_d[p] = EMPTY;
      endcase
    end
  end

  always_comb begin
    rd_idx_ready_O  = '0;
    rd_data_valid_O = '0;
    rd_data_O       = '0;
    accept          = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_data_valid_O[p]            = (state_q[p] == FULL);
      rd_idx_ready_O[p]             = !rst && ((state_q[p] == EMPTY) || rd_data_ready_I[p]);
      accept[p]                     = rd_idx_valid_I[p] && rd_idx_ready_O[p];
      rd_data_O[p*DATA_W +: DATA_W] = rd_data_q[p];
    end
  end

endmodule

// File: tb/tb_jpc_regfile_mp.sv
// Directed bench for jpc_regfile_mp: two-writer/zero-reg instance plus a writable-r0 instance.
module tb_jpc_regfile_mp;

  logic        clk;
  logic        rst;
  logic [9:0]  rd_idx;
  logic [1:0]  rd_idx_valid;
  logic [1:0]  rd_idx_ready;
  logic [63:0] rd_data;
  logic [1:0]  rd_data_valid;
  logic [1:0]  rd_data_ready;
  logic [9:0]  wr_idx;
  logic [63:0] wr_data;
  logic [1:0]  wr_valid;
  logic [1:0]  wr_ready;

  logic [4:0]  b_rd_idx;
  logic        b_rd_idx_valid;
  logic        b_rd_idx_ready;
  logic [31:0] b_rd_data;
  logic        b_rd_data_valid;
  logic        b_rd_data_ready;
  logic [4:0]  b_wr_idx;
  logic [31:0] b_wr_data;
  logic        b_wr_valid;
  logic        b_wr_ready;

  int npass = 0;
  int ntot  = 0;

  jpc_regfile_mp #(.NUM_REGS(32), .DATA_W(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst(rst),
    .rd_idx_I(rd_idx), .rd_idx_valid_I(rd_idx_valid), .rd_idx_ready_O(rd_idx_ready),
    .rd_data_O(rd_data), .rd_data_valid_O(rd_data_valid), .rd_data_ready_I(rd_data_ready),
    .wr_idx_I(wr_idx), .wr_data_I(wr_data), .wr_valid_I(wr_valid), .wr_ready_O(wr_ready)
  );

  jpc_regfile_mp #(.NUM_REGS(32), .DATA_W(32), .NUM_RD(1), .NUM_WR(1), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst(rst),
    .rd_idx_I(b_rd_idx), .rd_idx_valid_I(b_rd_idx_valid), .rd_idx_ready_O(b_rd_idx_ready),
    .rd_data_O(b_rd_data), .rd_data_valid_O(b_rd_data_valid), .rd_data_ready_I(b_rd_data_ready),
    .wr_idx_I(b_wr_idx), .wr_data_I(b_wr_data), .wr_valid_I(b_wr_valid), .wr_ready_O(b_wr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          wport;
    logic [4:0]  widx;
    logic [31:0] wdat;
    logic [4:0]  ridx;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  logic [31:0] exp_byp;

  initial begin
    rst = 1'b1;
    rd_idx = '0; rd_idx_valid = '0; rd_data_ready = 2'b11;
    wr_idx = '0; wr_data = '0; wr_valid = '0;
    b_rd_idx = '0; b_rd_idx_valid = 1'b0; b_rd_data_ready = 1'b1;
    b_wr_idx = '0; b_wr_data = '0; b_wr_valid = 1'b0;

    vecs[0] = '{0, 5'd5,  32'hDEADBEEF, 5'd5,  32'hDEADBEEF};
    vecs[1] = '{0, 5'd0,  32'h12345678, 5'd0,  32'h00000000};
    vecs[2] = '{1, 5'd31, 32'hCAFEF00D, 5'd31, 32'hCAFEF00D};
    vecs[3] = '{0, 5'd1,  32'h00000001, 5'd1,  32'h00000001};
    vecs[4] = '{1, 5'd2,  32'h00000002, 5'd2,  32'h00000002};
    vecs[5] = '{0, 5'd3,  32'h00000003, 5'd3,  32'h00000003};
    vecs[6] = '{1, 5'd7,  32'h00000011, 5'd7,  32'h00000011};
    vecs[7] = '{1, 5'd0,  32'h55555555, 5'd0,  32'h00000000};

    // Reset: one cycle, then release.
    tick();
    check("rst_valid",    32'(rd_data_valid), 32'd0);
    check("rst_idx_rdy",  32'(rd_idx_ready),  32'd0);
    check("rst_wr_rdy",   32'(wr_ready),      32'd0);
    check("rst_data",     rd_data[31:0],      32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_valid",   32'(rd_data_valid), 32'd0);
    check("post_rst_idx_rdy", 32'(rd_idx_ready),  32'd3);
    check("post_rst_wr_rdy",  32'(wr_ready),      32'd3);

    // Back-to-back sweep of all indices after reset.
    rd_idx_valid[0] = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rd_idx[4:0] = 5'(i);
      tick();
      check("sweep_valid", 32'(rd_data_valid[0]), 32'd1);
      check("sweep_data",  rd_data[31:0],         32'd0);
    end
    rd_idx_valid = '0;
    tick();
    check("sweep_drop", 32'(rd_data_valid[0]), 32'd0);

    // Table: write on a port, read back on read port 0.
    for (int v = 0; v < 8; v++) begin
      wr_valid = '0;
      wr_valid[vecs[v].wport] = 1'b1;
      wr_idx[vecs[v].wport*5 +: 5]   = vecs[v].widx;
      wr_data[vecs[v].wport*32 +: 32] = vecs[v].wdat;
      tick();
      wr_valid = '0;
      rd_idx_valid[0] = 1'b1;
      rd_idx[4:0] = vecs[v].ridx;
      tick();
      rd_idx_valid = '0;
      check("vec_valid", 32'(rd_data_valid[0]), 32'd1);
      check("vec_data",  rd_data[31:0],         vecs[v].exp);
      tick();
      check("vec_drop",  32'(rd_data_valid[0]), 32'd0);
    end

    // Both read ports hit r5 in the same cycle.
    rd_idx_valid = 2'b11;
    rd_idx = {5'd5, 5'd5};
    tick();
    rd_idx_valid = '0;
    check("dual_valid", 32'(rd_data_valid), 32'd3);
    check("dual_p0",    rd_data[31:0],      32'hDEADBEEF);
    check("dual_p1",    rd_data[63:32],     32'hDEADBEEF);
    tick();

    // Stall: snapshot of r7 must survive a write to r7.
    rd_idx_valid[0] = 1'b1;
    rd_idx[4:0] = 5'd7;
    tick();
    check("stall_first", rd_data[31:0], 32'h11);
    rd_data_ready[0] = 1'b0;
    wr_valid = 2'b01; wr_idx[4:0] = 5'd7; wr_data[31:0] = 32'h22;
    for (int k = 0; k < 3; k++) begin
      tick();
      wr_valid = '0;
      check("stall_data",    rd_data[31:0],          32'h11);
      check("stall_valid",   32'(rd_data_valid[0]),  32'd1);
      check("stall_idx_rdy", 32'(rd_idx_ready[0]),   32'd0);
    end
    rd_data_ready[0] = 1'b1;
    tick();
    rd_idx_valid = '0;
    check("stall_new_data",  rd_data[31:0],         32'h22);
    check("stall_new_valid", 32'(rd_data_valid[0]), 32'd1);
    tick();
    check("stall_drop", 32'(rd_data_valid[0]), 32'd0);

    // Two writers on r3 with a same-cycle read of r3.
`ifdef JPC_REGFILE_BYPASS_EN
    exp_byp = 32'h0000BBBB;
`else
    exp_byp = 32'h00000003;
`endif
    wr_valid = 2'b11;
    wr_idx = {5'd3, 5'd3};
    wr_data = {32'h0000BBBB, 32'h0000AAAA};
    rd_idx_valid[0] = 1'b1;
    rd_idx[4:0] = 5'd3;
    tick();
    wr_valid = '0;
    rd_idx_valid = '0;
    check("same_cycle_r3", rd_data[31:0], exp_byp);
    tick();

    // Back-to-back r1, r2, r3 then reset mid-stream.
    rd_idx_valid[0] = 1'b1;
    rd_idx[4:0] = 5'd1;
    tick();
    check("b2b_r1", rd_data[31:0], 32'h1);
    check("b2b_v1", 32'(rd_data_valid[0]), 32'd1);
    rd_idx[4:0] = 5'd2;
    tick();
    check("b2b_r2", rd_data[31:0], 32'h2);
    check("b2b_v2", 32'(rd_data_valid[0]), 32'd1);
    rd_idx[4:0] = 5'd3;
    tick();
    check("b2b_r3", rd_data[31:0], 32'h0000BBBB);
    check("b2b_v3", 32'(rd_data_valid[0]), 32'd1);
    rd_idx[4:0] = 5'd1;
    rst = 1'b1;
    tick();
    check("mid_rst_valid",   32'(rd_data_valid[0]), 32'd0);
    check("mid_rst_idx_rdy", 32'(rd_idx_ready),     32'd0);
    rst = 1'b0;
    tick();
    rd_idx_valid = '0;
    check("after_rst_valid", 32'(rd_data_valid[0]), 32'd1);
    check("after_rst_r1",    rd_data[31:0],         32'd0);
    tick();

    // Writable r0 instance.
    b_wr_valid = 1'b1; b_wr_idx = 5'd0; b_wr_data = 32'h12345678;
    tick();
    b_wr_valid = 1'b0;
    b_rd_idx_valid = 1'b1; b_rd_idx = 5'd0;
    tick();
    b_rd_idx_valid = 1'b0;
    check("b_r0_valid", 32'(b_rd_data_valid), 32'd1);
    check("b_r0_data",  b_rd_data,            32'h12345678);
    check("b_wr_rdy",   32'(b_wr_ready),      32'd1);
    tick();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
